// File: rtl/perceptron_pkg.sv
// perceptron_pkg
// Shared definitions for the perceptron training controller:
//   - state_t      : sequencer states (exposed on the debug port)
//   - LD_* codes   : encoding of the W1W0b_en_i load-select bus
//   - DEF_WIDTH    : default sample width, must match perceptron_dp
package perceptron_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LD_B   = 4'd1,
    ST_LD_W0  = 4'd2,
    ST_LD_W1  = 4'd3,
    ST_FEED   = 4'd4,
    ST_WAIT   = 4'd5,
    ST_READ   = 4'd6,
    ST_CAPT   = 4'd7,
    ST_RESULT = 4'd8,
    ST_UPD    = 4'd9
  } state_t;

  // W1W0b_en_i codes; the data bit on b_i/W0_i/W1_i is valid in the same cycle.
  localparam logic [1:0] LD_NONE = 2'b00;
  localparam logic [1:0] LD_B    = 2'b01;
  localparam logic [1:0] LD_W0   = 2'b10;
  localparam logic [1:0] LD_W1   = 2'b11;

endpackage

// File: rtl/perceptron_trainer_update.sv
// perceptron_update
// Combinational binary perceptron update rule (weights are +1/-1 stored as 1/0).
//   x0, x1   : signed sample of the misclassified example
//   target   : label (1 = class +1)
//   w0, w1   : current weights
//   b_new, w0_new, w1_new : updated bias/weights
// The bias always moves to the target. A weight follows sign(x)*target, which
// in the 1/0 encoding is target XOR sign-bit; a zero input carries no
// information about direction, so that weight is left unchanged.
module perceptron_update
  import perceptron_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic signed [WIDTH-1:0] x0,
  input  logic signed [WIDTH-1:0] x1,
  input  logic                    target,
  input  logic                    w0,
  input  logic                    w1,
  output logic                    b_new,
  output logic                    w0_new,
  output logic                    w1_new
);

  always_comb begin
    b_new  = target;
    w0_new = (x0 != '0) ? (target ^ x0[WIDTH-1]) : w0;
    w1_new = (x1 != '0) ? (target ^ x1[WIDTH-1]) : w1;
  end

endmodule

// File: rtl/perceptron_trainer.sv
// perceptron_trainer
// Sequencer and online-training controller driving perceptron_dp.
// Ports:
//   clk, reset            : clock (rising edge), async active-low reset
//   s_valid/s_ready       : sample stream; s_x0, s_x1 signed, s_target label,
//                           s_train enables the weight update on error
//   cfg_we, cfg_b/w0/w1   : load initial weights (only honoured in IDLE)
//   r_valid/r_ready       : result stream; r_y classification, r_err = r_y != target
//   err_cnt               : saturating count of training-mode errors
//   en_in_path, en_out_path, W1W0b_en_i, b_i, W0_i, W1_i, X0_i, X1_i : to perceptron_dp
//   Y_o                   : classification from perceptron_dp
//   dbg_state             : current sequencer state
//
// Handshake rule (both streams): a transfer happens at a rising edge where
// valid and ready are both high. r_valid is a pure function of the state and
// never looks at r_ready; once raised, r_valid/r_y/r_err hold until taken.
module perceptron_trainer
  import perceptron_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DP_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic signed [WIDTH-1:0] s_x0,
  input  logic signed [WIDTH-1:0] s_x1,
  input  logic                    s_target,
  input  logic                    s_train,
  input  logic                    cfg_we,
  input  logic                    cfg_b,
  input  logic                    cfg_w0,
  input  logic                    cfg_w1,
  output logic                    r_valid,
  input  logic                    r_ready,
  output logic                    r_y,
  output logic                    r_err,
  output logic [CNT_W-1:0]        err_cnt,
  output logic                    en_in_path,
  output logic                    en_out_path,
  output logic [1:0]              W1W0b_en_i,
  output logic                    b_i,
  output logic                    W0_i,
  output logic                    W1_i,
  output logic signed [WIDTH-1:0] X0_i,
  output logic signed [WIDTH-1:0] X1_i,
  input  logic                    Y_o,
  output logic [3:0]              dbg_state
);

  // WAIT counts 0 .. DP_LAT-1; keep at least one bit so DP_LAT <= 1 still elaborates.
  localparam int WC_W        = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
  localparam int WAIT_LAST_I = (DP_LAT > 0) ? DP_LAT - 1 : 0;
  localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_LAST_I);

  state_t                    state_q, state_d;
  logic                      b_q, w0_q, w1_q;
  logic                      dirty_q;
  logic signed [WIDTH-1:0]   x0_q, x1_q;
  logic                      tgt_q, trn_q;
  logic [WC_W-1:0]           wcnt_q;
  logic                      r_y_q, r_err_q;
  logic [CNT_W-1:0]          err_cnt_q;
  logic                      b_new, w0_new, w1_new;

  perceptron_update #(
    .WIDTH (WIDTH)
  ) u_update (
    .x0     (x0_q),
    .x1     (x1_q),
    .target (tgt_q),
    .w0     (w0_q),
    .w1     (w1_q),
    .b_new  (b_new),
    .w0_new (w0_new),
    .w1_new (w1_new)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. In IDLE a config write wins over everything, then a
  // pending reload, and only then a new sample.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_we)       state_d = ST_IDLE;
        else if (dirty_q) state_d = ST_LD_B;
        else if (s_valid) state_d = ST_FEED;
      end
      ST_LD_B:   state_d = ST_LD_W0;
      ST_LD_W0:  state_d = ST_LD_W1;
      ST_LD_W1:  state_d = ST_IDLE;
      ST_FEED:   state_d = (DP_LAT == 0) ? ST_READ : ST_WAIT;
      ST_WAIT:   if (wcnt_q == WAIT_LAST) state_d = ST_READ;
      ST_READ:   state_d = ST_CAPT;
      ST_CAPT:   state_d = ST_RESULT;
      ST_RESULT: begin
        if (r_ready) state_d = (trn_q && r_err_q) ? ST_UPD : ST_IDLE;
      end
      ST_UPD:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    s_ready     = 1'b0;
    r_valid     = 1'b0;
    en_in_path  = 1'b0;
    en_out_path = 1'b0;
    W1W0b_en_i  = LD_NONE;
    b_i         = 1'b0;
    W0_i        = 1'b0;
    W1_i        = 1'b0;
    unique case (state_q)
      ST_IDLE:   s_ready = !dirty_q && !cfg_we;
      ST_LD_B:   begin W1W0b_en_i = LD_B;  b_i  = b_q;  end
      ST_LD_W0:  begin W1W0b_en_i = LD_W0; W0_i = w0_q; end
      ST_LD_W1:  begin W1W0b_en_i = LD_W1; W1_i = w1_q; end
      ST_FEED:   en_in_path  = 1'b1;
      ST_READ:   en_out_path = 1'b1;
      ST_RESULT: r_valid     = 1'b1;
      default:   ;
    endcase
  end

  // Shadow weights, captured sample, wait counter, result and error counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      b_q       <= 1'b0;
      w0_q      <= 1'b1;
      w1_q      <= 1'b1;
      dirty_q   <= 1'b1;
      x0_q      <= '0;
      x1_q      <= '0;
      tgt_q     <= 1'b0;
      trn_q     <= 1'b0;
      wcnt_q    <= '0;
      r_y_q     <= 1'b0;
      r_err_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (state_q == ST_IDLE) begin
        if (cfg_we) begin
          b_q     <= cfg_b;
          w0_q    <= cfg_w0;
          w1_q    <= cfg_w1;
          dirty_q <= 1'b1;
        end else if (dirty_q) begin
          // Leaving for the load sequence; shadows are now in flight.
          dirty_q <= 1'b0;
        end else if (s_valid && s_ready) begin
          x0_q  <= s_x0;
          x1_q  <= s_x1;
          tgt_q <= s_target;
          trn_q <= s_train;
        end
      end

      if (state_q == ST_UPD) begin
        b_q     <= b_new;
        w0_q    <= w0_new;
        w1_q    <= w1_new;
        dirty_q <= 1'b1;
      end

      if (state_q == ST_FEED) wcnt_q <= '0;
      else if (state_q == ST_WAIT) wcnt_q <= wcnt_q + WC_W'(1);

      if (state_q == ST_CAPT) begin
        r_y_q   <= Y_o;
        r_err_q <= Y_o ^ tgt_q;
      end

      if (state_q == ST_RESULT && r_ready && trn_q && r_err_q && (err_cnt_q != '1))
        err_cnt_q <= err_cnt_q + CNT_W'(1);
    end
  end

  assign X0_i      = x0_q;
  assign X1_i      = x1_q;
  assign r_y       = r_y_q;
  assign r_err     = r_err_q;
  assign err_cnt   = err_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Testbench for perceptron_trainer. The bench plays the role of perceptron_dp
// (it drives Y_o) and keeps its own model of the weight shadows and error count.
module tb_perceptron_trainer;

  localparam int WIDTH   = 8;
  localparam int DP_LAT  = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic                    s_valid = 1'b0;
  logic                    s_ready;
  logic signed [WIDTH-1:0] s_x0 = '0;
  logic signed [WIDTH-1:0] s_x1 = '0;
  logic                    s_target = 1'b0;
  logic                    s_train = 1'b0;
  logic                    cfg_we = 1'b0;
  logic                    cfg_b = 1'b0;
  logic                    cfg_w0 = 1'b0;
  logic                    cfg_w1 = 1'b0;
  logic                    r_valid;
  logic                    r_ready = 1'b0;
  logic                    r_y;
  logic                    r_err;
  logic [CNT_W-1:0]        err_cnt;
  logic                    en_in_path;
  logic                    en_out_path;
  logic [1:0]              W1W0b_en_i;
  logic                    b_i;
  logic                    W0_i;
  logic                    W1_i;
  logic signed [WIDTH-1:0] X0_i;
  logic signed [WIDTH-1:0] X1_i;
  logic                    Y_o = 1'b0;
  logic [3:0]              dbg_state;

  perceptron_trainer #(
    .WIDTH  (WIDTH),
    .DP_LAT (DP_LAT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_x0        (s_x0),
    .s_x1        (s_x1),
    .s_target    (s_target),
    .s_train     (s_train),
    .cfg_we      (cfg_we),
    .cfg_b       (cfg_b),
    .cfg_w0      (cfg_w0),
    .cfg_w1      (cfg_w1),
    .r_valid     (r_valid),
    .r_ready     (r_ready),
    .r_y         (r_y),
    .r_err       (r_err),
    .err_cnt     (err_cnt),
    .en_in_path  (en_in_path),
    .en_out_path (en_out_path),
    .W1W0b_en_i  (W1W0b_en_i),
    .b_i         (b_i),
    .W0_i        (W0_i),
    .W1_i        (W1_i),
    .X0_i        (X0_i),
    .X1_i        (X1_i),
    .Y_o         (Y_o),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard / reference model ----------------
  int compared   = 0;
  int mismatched = 0;
  logic [1:0] exp_q[$];   // expected {r_y, r_err} per accepted sample
  logic m_b, m_w0, m_w1;  // model weights (1 = +1, 0 = -1)
  int   m_cnt;            // model error count

  // Perceptron rule in sign form: bias -> target, weight -> sign(x)*target.
  task automatic model_train(input int x0, input int x1, input bit tgt);
    m_b = tgt;
    if (x0 > 0) m_w0 = tgt; else if (x0 < 0) m_w0 = !tgt;
    if (x1 > 0) m_w1 = tgt; else if (x1 < 0) m_w1 = !tgt;
  endtask

  // ---------------- driver: one sample through the whole pipeline ----------------
  task automatic do_sample(input int x0, input int x1, input bit tgt, input bit trn,
                           input bit yv, input int rdly);
    int guard;
    bit err;
    logic [1:0] exp;
    logic [WIDTH-1:0] xa, xb;
    xa = x0[WIDTH-1:0];
    xb = x1[WIDTH-1:0];
    err = (yv != tgt);

    @(negedge clk);
    s_valid = 1'b1; s_x0 = xa; s_x1 = xb; s_target = tgt; s_train = trn;
    Y_o = yv; r_ready = 1'b0; cfg_we = 1'b0;
    guard = 0;
    while (s_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    compared++;
    if (guard >= 40) begin
      mismatched++;
      $display("FAIL accept_timeout: s_ready=%b required 1", s_ready);
      s_valid = 1'b0;
      return;
    end
    exp_q.push_back({yv, err});

    // FEED
    @(negedge clk);
    s_valid = 1'b0;
    compared++;
    if (en_in_path !== 1'b1 || X0_i !== xa || X1_i !== xb) begin
      mismatched++;
      $display("FAIL feed: en_in=%b X0=%0d X1=%0d required en_in=1 X0=%0d X1=%0d",
               en_in_path, X0_i, X1_i, $signed(xa), $signed(xb));
    end

    // WAIT; cfg_we here must be ignored
    for (int i = 0; i < DP_LAT; i++) begin
      @(negedge clk);
      cfg_we = $urandom_range(0, 1) == 1;
      cfg_b = $urandom_range(0, 1) == 1; cfg_w0 = $urandom_range(0, 1) == 1;
      cfg_w1 = $urandom_range(0, 1) == 1;
      compared++;
      if (en_in_path !== 1'b0 || en_out_path !== 1'b0 || r_valid !== 1'b0) begin
        mismatched++;
        $display("FAIL wait_quiet: en_in=%b en_out=%b r_valid=%b required 0 0 0",
                 en_in_path, en_out_path, r_valid);
      end
    end

    // READ
    @(negedge clk);
    cfg_we = 1'b0;
    compared++;
    if (en_out_path !== 1'b1 || X0_i !== xa || X1_i !== xb) begin
      mismatched++;
      $display("FAIL read: en_out=%b X0=%0d X1=%0d required en_out=1 and held sample",
               en_out_path, X0_i, X1_i);
    end

    // CAPT
    @(negedge clk);
    compared++;
    if (r_valid !== 1'b0 || en_out_path !== 1'b0) begin
      mismatched++;
      $display("FAIL capt: r_valid=%b en_out=%b required 0 0", r_valid, en_out_path);
    end

    // RESULT
    @(negedge clk);
    exp = exp_q.pop_front();
    compared++;
    if (r_valid !== 1'b1 || {r_y, r_err} !== exp) begin
      mismatched++;
      $display("FAIL result: r_valid=%b r_y=%b r_err=%b required 1 %b %b",
               r_valid, r_y, r_err, exp[1], exp[0]);
    end
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      compared++;
      if (r_valid !== 1'b1 || {r_y, r_err} !== exp || s_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL result_hold: r_valid=%b r_y=%b r_err=%b s_ready=%b required 1 %b %b 0",
                 r_valid, r_y, r_err, s_ready, exp[1], exp[0]);
      end
    end
    r_ready = 1'b1;

    // cycle after the handshake
    @(negedge clk);
    r_ready = 1'b0;
    if (trn && err && m_cnt < CNT_MAX) m_cnt++;
    compared++;
    if (r_valid !== 1'b0 || err_cnt !== CNT_W'(m_cnt)) begin
      mismatched++;
      $display("FAIL after_result: r_valid=%b err_cnt=%0d required 0 %0d", r_valid, err_cnt, m_cnt);
    end

    if (trn && err) begin
      model_train(x0, x1, tgt);
      compared++;
      if (s_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL upd_not_ready: s_ready=%b required 0", s_ready);
      end
      guard = 0;
      while (W1W0b_en_i !== 2'b01 && guard < 5) begin
        @(negedge clk);
        guard++;
      end
      compared++;
      if (guard != 2 || b_i !== m_b) begin
        mismatched++;
        $display("FAIL reload_b: delay=%0d b_i=%b required delay 2 b_i=%b", guard, b_i, m_b);
      end
      @(negedge clk);
      compared++;
      if (W1W0b_en_i !== 2'b10 || W0_i !== m_w0) begin
        mismatched++;
        $display("FAIL reload_w0: sel=%b W0_i=%b required 10 %b", W1W0b_en_i, W0_i, m_w0);
      end
      @(negedge clk);
      compared++;
      if (W1W0b_en_i !== 2'b11 || W1_i !== m_w1) begin
        mismatched++;
        $display("FAIL reload_w1: sel=%b W1_i=%b required 11 %b", W1W0b_en_i, W1_i, m_w1);
      end
      @(negedge clk);
    end
    compared++;
    if (s_ready !== 1'b1 || W1W0b_en_i !== 2'b00) begin
      mismatched++;
      $display("FAIL next_ready: s_ready=%b sel=%b required 1 00", s_ready, W1W0b_en_i);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; s_valid = 1'b0; cfg_we = 1'b0; r_ready = 1'b0;
    #1;
    compared++;
    if ({s_ready, r_valid, r_y, r_err, err_cnt, en_in_path, en_out_path, W1W0b_en_i,
         b_i, W0_i, W1_i, X0_i, X1_i} !== '0) begin
      mismatched++;
      $display("FAIL reset_outputs: s_ready=%b r_valid=%b r_y=%b r_err=%b err_cnt=%0d en_in=%b en_out=%b sel=%b b=%b w0=%b w1=%b X0=%0d X1=%0d required all 0",
               s_ready, r_valid, r_y, r_err, err_cnt, en_in_path, en_out_path, W1W0b_en_i,
               b_i, W0_i, W1_i, X0_i, X1_i);
    end
    m_b = 1'b0; m_w0 = 1'b1; m_w1 = 1'b1; m_cnt = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    compared++;
    if (W1W0b_en_i !== 2'b01 || b_i !== m_b || s_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL boot_cycle1: sel=%b b_i=%b s_ready=%b required 01 %b 0", W1W0b_en_i, b_i, s_ready, m_b);
    end
    @(negedge clk);
    compared++;
    if (W1W0b_en_i !== 2'b10 || W0_i !== m_w0) begin
      mismatched++;
      $display("FAIL boot_cycle2: sel=%b W0_i=%b required 10 %b", W1W0b_en_i, W0_i, m_w0);
    end
    @(negedge clk);
    compared++;
    if (W1W0b_en_i !== 2'b11 || W1_i !== m_w1) begin
      mismatched++;
      $display("FAIL boot_cycle3: sel=%b W1_i=%b required 11 %b", W1W0b_en_i, W1_i, m_w1);
    end
    @(negedge clk);
    compared++;
    if (s_ready !== 1'b1 || W1W0b_en_i !== 2'b00) begin
      mismatched++;
      $display("FAIL boot_cycle4: s_ready=%b sel=%b required 1 00", s_ready, W1W0b_en_i);
    end
  endtask

  task automatic test_directed();
    do_sample(5, -3, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 0);
    do_sample(10, -4, 1'b0, 1'b1, 1'b1, 0);   // error -> b=0, w0=0, w1=1
    do_sample(0, 7, 1'b1, 1'b1, 1'b0, 0);     // error -> b=1, w0 kept, w1=1
    do_sample(-20, 3, 1'b0, 1'b1, 1'b0, 5);   // no error, long r_ready stall
    do_sample(-8, -9, 1'b1, 1'b1, 1'b0, 5);   // error with stall
  endtask

  task automatic test_cfg_priority();
    int guard;
    bit nb, nw0, nw1;
    nb = $urandom_range(0, 1) == 1; nw0 = $urandom_range(0, 1) == 1; nw1 = $urandom_range(0, 1) == 1;
    @(negedge clk);
    guard = 0;
    while (s_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    s_valid = 1'b1; s_x0 = 8'sd12; s_x1 = -8'sd5; s_target = 1'b1; s_train = 1'b0;
    cfg_we = 1'b1; cfg_b = nb; cfg_w0 = nw0; cfg_w1 = nw1;
    #1;
    compared++;
    if (s_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL cfg_blocks_ready: s_ready=%b required 0", s_ready);
    end
    m_b = nb; m_w0 = nw0; m_w1 = nw1;
    @(negedge clk);
    cfg_we = 1'b0;
    compared++;
    if (s_ready !== 1'b0 || en_in_path !== 1'b0) begin
      mismatched++;
      $display("FAIL cfg_no_accept: s_ready=%b en_in=%b required 0 0", s_ready, en_in_path);
    end
    @(negedge clk);
    compared++;
    if (W1W0b_en_i !== 2'b01 || b_i !== m_b || en_in_path !== 1'b0) begin
      mismatched++;
      $display("FAIL cfg_load_b: sel=%b b_i=%b en_in=%b required 01 %b 0", W1W0b_en_i, b_i, en_in_path, m_b);
    end
    @(negedge clk);
    compared++;
    if (W1W0b_en_i !== 2'b10 || W0_i !== m_w0) begin
      mismatched++;
      $display("FAIL cfg_load_w0: sel=%b W0_i=%b required 10 %b", W1W0b_en_i, W0_i, m_w0);
    end
    @(negedge clk);
    compared++;
    if (W1W0b_en_i !== 2'b11 || W1_i !== m_w1) begin
      mismatched++;
      $display("FAIL cfg_load_w1: sel=%b W1_i=%b required 11 %b", W1W0b_en_i, W1_i, m_w1);
    end
    s_valid = 1'b0;
    do_sample(12, -5, 1'b1, 1'b0, 1'b1, 1);
  endtask

  task automatic test_random(input int n);
    logic signed [WIDTH-1:0] a, b;
    for (int i = 0; i < n; i++) begin
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      if ($urandom_range(0, 4) == 0) a = '0;
      if ($urandom_range(0, 4) == 0) b = '0;
      do_sample(int'(a), int'(b), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    @(negedge clk);
    s_valid = 1'b1; s_x0 = 8'sd33; s_x1 = -8'sd17; s_target = 1'b0; s_train = 1'b1; Y_o = 1'b1;
    guard = 0;
    while (s_ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);   // FEED
    s_valid = 1'b0;
    @(negedge clk);   // WAIT
    test_reset();
    do_sample(-2, 9, 1'b1, 1'b0, 1'b1, 0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < CNT_MAX + 3; i++)
      do_sample(int'($urandom_range(1, 100)), -int'($urandom_range(1, 100)), 1'b1, 1'b1, 1'b0, 0);
    compared++;
    if (err_cnt !== CNT_W'(CNT_MAX)) begin
      mismatched++;
      $display("FAIL err_cnt_saturate: err_cnt=%0d required %0d", err_cnt, CNT_MAX);
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_directed();
    test_cfg_priority();
    test_random(40);
    test_reset_mid();
    test_saturation();
    test_random(10);
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_leftover: %0d entries required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
